func_stream_aligner: RTL and testbench
======================================

Name: func_stream_aligner

Overview:
- Input-side stage that sits directly upstream of the TyBEC kernel wrapper.
- Accepts N independent AXI4-Stream input channels, each with its own handshake, and buffers each channel in a small FIFO.
- Presents a joined stream to the kernel wrapper: all channels valid in the same cycle, all channels consumed in the same cycle.
- Absorbs inter-channel skew from the memory readers, so the kernel's all-valid join never stalls on a channel that is only a few beats late.

Parameters:
- C_DATA_WIDTH, 32, width of each channel's data word (32 * vector width, max 512).
- C_NUM_CHANNELS, 2, number of input channels; legal range 1..8.
- C_FIFO_DEPTH, 4, entries per channel FIFO; power of 2, minimum 2.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- s_tvalid  in  C_NUM_CHANNELS  per-channel upstream valid.
- s_tdata  in  C_NUM_CHANNELS x C_DATA_WIDTH  per-channel upstream data (packed 2-D).
- s_tready  out  C_NUM_CHANNELS  per-channel ready to upstream.
- m_tvalid  out  C_NUM_CHANNELS  joined valid to kernel wrapper; all bits are always equal.
- m_tdata  out  C_NUM_CHANNELS x C_DATA_WIDTH  FIFO head data per channel.
- m_tready  in  C_NUM_CHANNELS  ready from kernel wrapper; the wrapper drives all-ones or all-zeros.
- fifo_level  out  C_NUM_CHANNELS x ($clog2(C_FIFO_DEPTH)+1)  per-channel occupancy.

Behaviour:
- Clock and reset: one clock, aclk. areset is synchronous and active-high.
- Reset values:
  - s_tready = all 0 during the reset cycle; all 1 from the first cycle after areset deasserts.
  - m_tvalid = all 0; fifo_level = all 0.
  - m_tdata content undefined; storage is not reset.
- Per-channel FIFO (circular):
  - State per channel: wr_ptr, rd_ptr, count.
  - Pointers wrap from C_FIFO_DEPTH-1 to 0.
  - full = (count == C_FIFO_DEPTH); empty = (count == 0).
- Push, channel i:
  - push_i = s_tvalid[i] & s_tready[i].
  - s_tready[i] = !full_i & !areset. Registered-free: combinational from count.
  - No push-through-when-full: a full FIFO deasserts ready even if a pop happens in the same cycle.
- Join:
  - join_valid = AND over all channels of !empty_i.
  - m_tvalid = {C_NUM_CHANNELS{join_valid}}.
  - m_tdata[i] = head entry of FIFO i (first-word fall-through from the storage array).
- Pop:
  - pop = join_valid & (&m_tready).
  - On pop, every channel's rd_ptr advances in the same cycle.
  - A partial m_tready (not all ones) is treated as no pop.
- Latency: a word pushed at edge t appears at m_tdata / m_tvalid after edge t, i.e. 1 cycle, provided all other channels are non-empty.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance.
- Empty channel: m_tvalid stays 0 for all channels; the other channels keep filling until full, then backpressure.
- Ordering: per-channel order is strictly preserved. The Nth pop returns the Nth word of every channel.
- AXI stability rule: once m_tvalid is asserted, m_tvalid and m_tdata stay stable until pop. Guaranteed because only pops remove entries.
- Reset mid-operation: pointers and counts clear on that edge; all buffered words are discarded; m_tvalid = 0 in the following cycle.
- fifo_level[i] = count_i, registered.

Optional Feature:
- Macro: FUNC_ALIGN_STATS_EN.
- When defined, adds output stall_cycles (32 bits) and output skew_max ($clog2(C_FIFO_DEPTH)+1 bits).
  - stall_cycles increments each cycle where at least one FIFO is non-empty and join_valid = 0. Saturates at 0xFFFFFFFF.
  - skew_max holds the running maximum of (max count - min count) across channels.
  - Both clear on areset.
- When undefined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset release, both channels idle -> m_tvalid=00, s_tready=11, fifo_level=0/0.
- Ch0 pushes 0x11,0x22; ch1 pushes 0xA1 two cycles later; m_tready=11 -> first pop gives {0xA1,0x11}; m_tvalid stays 00 until ch1's push is seen.
- Ch0 driven 6 beats (0x1..0x6) with ch1 idle, depth 4 -> s_tready[0]=0 after the 4th accept; beats 5-6 held by the source; no data loss once ch1 supplies 4 beats.
- Both channels streaming continuously with m_tready=11 -> one pop per cycle, fifo_level steady at 1, throughput 1 word/cycle.
- m_tready=00 for 5 cycles with m_tvalid=11 -> m_tdata unchanged across all 5 cycles; FIFOs fill to 4 and s_tready=00.
- areset pulsed with fifo_level=3/2 -> next cycle m_tvalid=00, fifo_level=0/0; words pushed afterwards emerge first (no stale data).

Source files
------------

// File: rtl/func_stream_aligner_if.sv
// Stream bundle between the memory-reader side and the kernel-wrapper side of
// func_stream_aligner. Every per-channel signal is one bit (or word) per lane.
// The aligner takes the "slave" view, which accepts s_* and produces m_*.
// The environment (readers plus wrapper) takes the "master" view.
interface func_stream_aligner_if #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2
);
  logic [C_NUM_CHANNELS-1:0]                   s_tvalid;
  logic [C_NUM_CHANNELS-1:0]                   s_tready;
  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] s_tdata;
  logic [C_NUM_CHANNELS-1:0]                   m_tvalid;
  logic [C_NUM_CHANNELS-1:0]                   m_tready;
  logic [C_NUM_CHANNELS-1:0][C_DATA_WIDTH-1:0] m_tdata;

  modport master (
    output s_tvalid, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tdata
  );

  modport slave (
    input  s_tvalid, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tdata
  );
endinterface

// File: rtl/func_stream_aligner.sv
// func_stream_aligner: buffers each AXI4-Stream input channel in a small FWFT
// circular FIFO and presents a joined stream. The joined stream is valid only
// when every channel holds a word, and all channels pop together. This absorbs
// the skew between memory readers in front of the kernel's all-valid join.
// Optional build macro FUNC_ALIGN_STATS_EN adds the stall_cycles and skew_max
// statistics outputs.
module func_stream_aligner #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_NUM_CHANNELS = 2,
  parameter int C_FIFO_DEPTH   = 4
) (
  input  logic                                                   aclk,
  input  logic                                                   areset,
  func_stream_aligner_if.slave                                   bus,
`ifdef FUNC_ALIGN_STATS_EN
  output logic [31:0]                                            stall_cycles,
  output logic [$clog2(C_FIFO_DEPTH):0]                          skew_max,
`endif
  output logic [C_NUM_CHANNELS-1:0][$clog2(C_FIFO_DEPTH):0]      fifo_level
);

  localparam int PW = $clog2(C_FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [C_DATA_WIDTH-1:0]           mem [C_NUM_CHANNELS][C_FIFO_DEPTH];
  logic [C_NUM_CHANNELS-1:0][PW-1:0] wr_ptr;
  logic [C_NUM_CHANNELS-1:0][PW-1:0] rd_ptr;
  logic [C_NUM_CHANNELS-1:0][LW-1:0] count;
  logic [C_NUM_CHANNELS-1:0]         full;
  logic [C_NUM_CHANNELS-1:0]         empty;
  logic [C_NUM_CHANNELS-1:0]         push;
  logic                              join_valid;
  logic                              pop;

  // Per-channel flags, ready and push qualification. A full FIFO refuses a
  // push even when a pop is happening in the same cycle.
  always_comb begin
    full  = '0;
    empty = '0;
    push  = '0;
    bus.s_tready = '0;
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      full[i]         = (count[i] == LW'(C_FIFO_DEPTH));
      empty[i]        = (count[i] == '0);
      bus.s_tready[i] = !full[i] && !areset;
      push[i]         = bus.s_tvalid[i] && bus.s_tready[i];
    end
  end

  // Join: all channels valid together. A partial m_tready does not pop.
  always_comb begin
    join_valid   = &(~empty);
    pop          = join_valid && (&bus.m_tready);
    bus.m_tvalid = {C_NUM_CHANNELS{join_valid}};
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      bus.m_tdata[i] = mem[i][rd_ptr[i]];
    end
  end

  // Storage array. It is not reset; only pointers define which words are live.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      if (push[i]) begin
        mem[i][wr_ptr[i]] <= bus.s_tdata[i];
      end
    end
  end

  // Pointer and occupancy state. Pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < C_NUM_CHANNELS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop)     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  assign fifo_level = count;

`ifdef FUNC_ALIGN_STATS_EN
  logic [LW-1:0] cnt_max;
  logic [LW-1:0] cnt_min;
  logic [LW-1:0] skew_now;

  // Current spread between the fullest and the emptiest channel.
  always_comb begin
    cnt_max = '0;
    cnt_min = count[0];
    for (int i = 0; i < C_NUM_CHANNELS; i++) begin
      if (count[i] > cnt_max) cnt_max = count[i];
      if (count[i] < cnt_min) cnt_min = count[i];
    end
    skew_now = cnt_max - cnt_min;
  end

  // Saturating stall counter and running skew maximum.
  always_ff @(posedge aclk) begin
    if (areset) begin
      stall_cycles <= '0;
      skew_max     <= '0;
    end else begin
      if ((|(~empty)) && !join_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (skew_now > skew_max) begin
        skew_max <= skew_now;
      end
    end
  end
`endif

endmodule

// File: tb/tb_func_stream_aligner.sv
// Directed bench for func_stream_aligner with 2 channels, 32-bit data and depth 4.
// Source queues model the upstream readers, which hold a beat until it is
// accepted. Expected queues hold the words each channel must deliver in order.
module tb_func_stream_aligner;

  logic clk;
  logic areset;
  logic [1:0][2:0] level;

  int tests = 0;
  int fails = 0;
  int npop  = 0;

  logic [31:0] q0[$], q1[$], e0[$], e1[$];

  func_stream_aligner_if #(.C_DATA_WIDTH(32), .C_NUM_CHANNELS(2)) bus ();

  func_stream_aligner #(
    .C_DATA_WIDTH(32),
    .C_NUM_CHANNELS(2),
    .C_FIFO_DEPTH(4)
  ) dut (
    .aclk(clk),
    .areset(areset),
    .bus(bus),
    .fifo_level(level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle per iteration: offer queue heads, score any pop, then advance.
  task automatic run(input int n);
    logic acc0, acc1;
    logic [31:0] x0, x1;
    for (int k = 0; k < n; k++) begin
      bus.s_tvalid[0] = (q0.size() > 0);
      bus.s_tvalid[1] = (q1.size() > 0);
      bus.s_tdata[0]  = (q0.size() > 0) ? q0[0] : 32'h0;
      bus.s_tdata[1]  = (q1.size() > 0) ? q1[0] : 32'h0;
      #1;
      acc0 = bus.s_tvalid[0] && bus.s_tready[0];
      acc1 = bus.s_tvalid[1] && bus.s_tready[1];
      if (bus.m_tvalid[0] && (&bus.m_tready)) begin
        if (e0.size() > 0 && e1.size() > 0) begin
          x0 = e0.pop_front();
          x1 = e1.pop_front();
          check("pop_data", 64'(bus.m_tdata), {x1, x0});
        end else begin
          check("pop_spurious", 64'(e0.size() + e1.size()), 64'd2);
        end
        npop++;
      end
      @(posedge clk);
      #1;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
    end
    bus.s_tvalid = 2'b00;
  endtask

  initial begin
    areset       = 1'b1;
    bus.s_tvalid = 2'b00;
    bus.s_tdata  = '0;
    bus.m_tready = 2'b11;
    tick();
    tick();
    check("rst_s_tready", 64'(bus.s_tready), 64'h0);
    check("rst_m_tvalid", 64'(bus.m_tvalid), 64'h0);
    check("rst_level", 64'(level), 64'h0);

    // Reset release, idle
    areset = 1'b0;
    tick();
    check("idle_s_tready", 64'(bus.s_tready), 64'h3);
    check("idle_m_tvalid", 64'(bus.m_tvalid), 64'h0);
    check("idle_level", 64'(level), 64'h0);

    // Skewed arrival: ch1 two cycles behind ch0
    q0 = '{32'h11, 32'h22};
    e0 = '{32'h11, 32'h22};
    e1 = '{32'hA1, 32'hB2};
    run(2);
    check("skew_m_tvalid_wait", 64'(bus.m_tvalid), 64'h0);
    check("skew_level", 64'(level), 64'h02);
    q1 = '{32'hA1};
    run(1);
    check("skew_m_tvalid", 64'(bus.m_tvalid), 64'h3);
    check("skew_first_word", 64'(bus.m_tdata), 64'h0000_00A1_0000_0011);
    run(1);
    check("skew_after_pop_valid", 64'(bus.m_tvalid), 64'h0);
    check("skew_after_pop_level", 64'(level), 64'h01);
    q1 = '{32'hB2};
    run(3);
    check("skew_drained", 64'(level), 64'h0);
    check("skew_all_popped", 64'(e0.size() + e1.size()), 64'd0);

    // Backpressure: ch0 offers 6 beats, ch1 idle
    npop = 0;
    q0 = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    e0 = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    e1 = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
    run(6);
    check("bp_s_tready", 64'(bus.s_tready), 64'h2);
    check("bp_level_full", 64'(level), 64'h04);
    check("bp_beats_held", 64'(q0.size()), 64'd2);
    check("bp_m_tvalid", 64'(bus.m_tvalid), 64'h0);
    q1 = '{32'h100, 32'h101, 32'h102, 32'h103};
    run(8);
    check("bp_level_mid", 64'(level), 64'h02);
    check("bp_pops_mid", 64'(npop), 64'd4);
    check("bp_src_done", 64'(q0.size()), 64'd0);
    q1 = '{32'h104, 32'h105};
    run(4);
    check("bp_level_end", 64'(level), 64'h0);
    check("bp_pops_end", 64'(npop), 64'd6);
    check("bp_no_loss", 64'(e0.size() + e1.size()), 64'd0);

    // Continuous streaming at one word per cycle
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(32'h200 + i);
      e0.push_back(32'h200 + i);
      q1.push_back(32'h300 + i);
      e1.push_back(32'h300 + i);
    end
    run(5);
    check("stream_level", 64'(level), 64'h09);
    check("stream_pops5", 64'(npop), 64'd4);
    run(5);
    check("stream_pops10", 64'(npop), 64'd8);
    check("stream_level_end", 64'(level), 64'h0);

    // Kernel stalls: m_tready low, output must hold
    npop = 0;
    bus.m_tready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      q0.push_back(32'h400 + i);
      e0.push_back(32'h400 + i);
      q1.push_back(32'h500 + i);
      e1.push_back(32'h500 + i);
    end
    run(1);
    for (int k = 0; k < 5; k++) begin
      check("hold_m_tvalid", 64'(bus.m_tvalid), 64'h3);
      check("hold_m_tdata", 64'(bus.m_tdata), 64'h0000_0500_0000_0400);
      run(1);
    end
    check("hold_level_full", 64'(level), 64'h24);
    check("hold_s_tready", 64'(bus.s_tready), 64'h0);
    check("hold_pops", 64'(npop), 64'd0);
    bus.m_tready = 2'b11;
    run(8);
    check("hold_drain_pops", 64'(npop), 64'd5);
    check("hold_drain_level", 64'(level), 64'h0);

    // Reset mid-operation discards buffered words
    bus.m_tready = 2'b00;
    q0 = '{32'h600, 32'h601, 32'h602};
    q1 = '{32'h700, 32'h701};
    run(3);
    check("mid_level_pre", 64'(level), 64'h13);
    areset = 1'b1;
    #1;
    check("mid_rst_s_tready", 64'(bus.s_tready), 64'h0);
    tick();
    areset = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 64'(bus.m_tvalid), 64'h0);
    check("mid_rst_level", 64'(level), 64'h0);
    check("mid_rst_s_tready_back", 64'(bus.s_tready), 64'h3);
    npop = 0;
    e0.delete();
    e1.delete();
    bus.m_tready = 2'b11;
    q0 = '{32'h800};
    q1 = '{32'h900};
    e0 = '{32'h800};
    e1 = '{32'h900};
    run(1);
    check("mid_fresh_word", 64'(bus.m_tdata), 64'h0000_0900_0000_0800);
    run(2);
    check("mid_fresh_pops", 64'(npop), 64'd1);
    check("mid_fresh_level", 64'(level), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
